reg_file_write_port: RTL and testbench

- Write side of the LC-3 register file; the counterpart of the 8-to-1 read-port muxes.
- Accepts write-back requests (destination register, data, set-condition-code flag) from the datapath through a valid/ready handshake.
- Buffers requests in a 2-entry FIFO and drains one request per cycle into the eight 16-bit general registers R0–R7, updating the NZP condition codes when the request asks for it.
- Exports all eight register values to the read muxes, plus a per-register pending bitmap for hazard detection in the control unit.

---
 rtl/lc3_rf_pkg.sv | 29 ++
 rtl/reg_file_write_port_if.sv | 22 ++
 rtl/reg_file_write_port_wb_fifo.sv | 60 ++++++
 rtl/reg_file_write_port.sv | 87 ++++++++
 tb/tb_reg_file_write_port.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3_rf_pkg.sv
// Shared types and constants for the LC-3 register-file write port.
// Also holds the condition-code helper used at retire time.
package lc3_rf_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dr;
    logic [DATA_W-1:0]    data;
    logic                 set_cc;
  } wr_entry_t;

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] data);
    if (data[DATA_W-1]) begin
      return CC_N;
    end else if (data == '0) begin
      return CC_Z;
    end else begin
      return CC_P;
    end
  endfunction

endpackage

// File: rtl/reg_file_write_port_if.sv
// Write-back request channel from the datapath: valid/ready plus {dr, data, set_cc}.
// master = requester, slave = register-file write port.
interface reg_file_write_port_if;
  import lc3_rf_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [REG_IDX_W-1:0] wr_dr;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_set_cc;

  modport master (
    output wr_valid, wr_dr, wr_data, wr_set_cc,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_dr, wr_data, wr_set_cc,
    output wr_ready
  );

endinterface

// File: rtl/reg_file_write_port_wb_fifo.sv
// Synchronous FIFO with per-slot peek outputs; push visible on the following cycle, no bypass.
// Backpressure: full when count==DEPTH; push and pop requests are ignored when full/empty respectively.
module wb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  T                             push_dat,
  output T                             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output T                             peek [DEPTH],
  output logic [DEPTH-1:0]             peek_vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: slots are only observed through count/peek_vld.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // A slot is live when its distance from the head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_peek
    logic [PW-1:0] off;
    assign off         = PW'(g) - rd_ptr;
    assign peek_vld[g] = (CW'(off) < count);
    assign peek[g]     = mem[g];
  end

endmodule

// File: rtl/reg_file_write_port.sv
// LC-3 register-file write side: buffered write-back into R0-R7 and NZP, one retire per cycle, result on r* the cycle after push at the earliest.
// Backpressure: wr_ready = !full of the write buffer, independent of drain_en.
module reg_file_write_port
  import lc3_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_file_write_port_if.slave   wr,
  input  logic                   drain_en,
  output logic [DATA_W-1:0]      r0,
  output logic [DATA_W-1:0]      r1,
  output logic [DATA_W-1:0]      r2,
  output logic [DATA_W-1:0]      r3,
  output logic [DATA_W-1:0]      r4,
  output logic [DATA_W-1:0]      r5,
  output logic [DATA_W-1:0]      r6,
  output logic [DATA_W-1:0]      r7,
  output logic [NUM_REGS-1:0]    busy,
  output logic [2:0]             nzp,
  output logic                   empty
);

  wr_entry_t                       push_ent;
  wr_entry_t                       head;
  wr_entry_t                       peek [DEPTH];
  logic [DEPTH-1:0]                peek_vld;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(DEPTH+1)-1:0]      fifo_count;
  logic                            retire;
  logic [DATA_W-1:0]               regs [NUM_REGS];

  assign push_ent.dr     = wr.wr_dr;
  assign push_ent.data   = wr.wr_data;
  assign push_ent.set_cc = wr.wr_set_cc;

  wb_fifo #(
    .T     (wr_entry_t),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr.wr_valid),
    .pop      (drain_en),
    .push_dat (push_ent),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .peek     (peek),
    .peek_vld (peek_vld)
  );

  assign wr.wr_ready = !fifo_full;
  assign empty       = (fifo_count == '0);
  assign retire      = drain_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      nzp <= CC_Z;
    end else if (retire) begin
      regs[head.dr] <= head.data;
      if (head.set_cc) nzp <= cc_of(head.data);
    end
  end

  // Every live entry marks its destination, including the head until it pops.
  always_comb begin
    busy = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (peek_vld[j]) busy[peek[j].dr] = 1'b1;
    end
  end

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule

// File: tb/tb_reg_file_write_port.sv
// Bench for reg_file_write_port: directed scenarios plus random traffic against a queue-based model.
module tb_reg_file_write_port;
  import lc3_rf_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  busy;
  logic [2:0]  nzp;
  logic        empty;
  logic [15:0] rv [8];

  always #5 clk = ~clk;

  reg_file_write_port_if wif();

  reg_file_write_port #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wif),
    .drain_en (drain_en),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .r5       (r5),
    .r6       (r6),
    .r7       (r7),
    .busy     (busy),
    .nzp      (nzp),
    .empty    (empty)
  );

  assign rv[0] = r0;
  assign rv[1] = r1;
  assign rv[2] = r2;
  assign rv[3] = r3;
  assign rv[4] = r4;
  assign rv[5] = r5;
  assign rv[6] = r6;
  assign rv[7] = r7;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a bounded queue of pending writes plus the architectural state.
  typedef struct {
    int dr;
    int data;
    bit set_cc;
  } req_t;

  req_t mq[$];
  int   m_reg [8];
  int   m_nzp;

  function automatic int model_cc(input int d);
    if (d >= 32768) return 4;
    if (d == 0)     return 2;
    return 1;
  endfunction

  task automatic model_edge();
    bit   acc;
    req_t h;
    if (!rst_n) begin
      mq.delete();
      foreach (m_reg[i]) m_reg[i] = 0;
      m_nzp = 2;
    end else begin
      acc = wif.wr_valid && (mq.size() < DEPTH);
      if (drain_en && mq.size() > 0) begin
        h = mq.pop_front();
        m_reg[h.dr] = h.data;
        if (h.set_cc) m_nzp = model_cc(h.data);
      end
      if (acc) mq.push_back('{int'(wif.wr_dr), int'(wif.wr_data), wif.wr_set_cc});
    end
  endtask

  task automatic check_model();
    int b;
    b = 0;
    for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), 32'(rv[i]), m_reg[i]);
    check("nzp", 32'(nzp), m_nzp);
    foreach (mq[k]) b = b | (1 << mq[k].dr);
    check("busy", 32'(busy), b);
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("wr_ready", 32'(wif.wr_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic step(input logic rst, input logic v, input logic [2:0] dr,
                      input logic [15:0] data, input logic cc, input logic drn);
    rst_n          = rst;
    wif.wr_valid   = v;
    wif.wr_dr      = dr;
    wif.wr_data    = data;
    wif.wr_set_cc  = cc;
    drain_en       = drn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wif.wr_valid  = 1'b0;
    wif.wr_dr     = '0;
    wif.wr_data   = '0;
    wif.wr_set_cc = 1'b0;
    @(negedge clk);

    // Reset after random pushes
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 3'($urandom_range(7)), 16'($urandom), 1'($urandom), 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ready", 32'(wif.wr_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_nzp", 32'(nzp), 32'b010);

    // Single write with negative data
    step(1'b1, 1'b1, 3'd3, 16'h8001, 1'b1, 1'b1);
    check("t2_busy_on", 32'(busy), 32'h08);
    check("t2_r3_pre", 32'(r3), 0);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    check("t2_r3", 32'(r3), 32'h8001);
    check("t2_nzp", 32'(nzp), 32'b100);
    check("t2_busy_off", 32'(busy), 0);

    // Fill and stall, then drain
    step(1'b1, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 16'h0000, 1'b1, 1'b0);
    check("t3_ready", 32'(wif.wr_ready), 0);
    check("t3_busy", 32'(busy), 32'h06);
    step(1'b1, 1'b1, 3'd7, 16'h7777, 1'b1, 1'b0);
    check("t3_busy_hold", 32'(busy), 32'h06);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    check("t3_r1", 32'(r1), 5);
    check("t3_nzp_keep", 32'(nzp), 32'b100);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    check("t3_r2", 32'(r2), 0);
    check("t3_nzp_z", 32'(nzp), 32'b010);
    check("t3_r7", 32'(r7), 0);

    // Same-register ordering
    step(1'b1, 1'b1, 3'd4, 16'h1111, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd4, 16'h2222, 1'b0, 1'b1);
    check("t4_r4_first", 32'(r4), 32'h1111);
    check("t4_busy", 32'(busy), 32'h10);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    check("t4_r4_last", 32'(r4), 32'h2222);
    check("t4_busy_off", 32'(busy), 0);

    // Concurrent push and pop, then streaming across all registers
    step(1'b1, 1'b1, 3'd5, 16'h0055, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd6, 16'h0066, 1'b1, 1'b1);
    check("t5_empty", 32'(empty), 0);
    check("t5_ready", 32'(wif.wr_ready), 1);
    check("t5_r5", 32'(r5), 32'h0055);
    check("t5_busy", 32'(busy), 32'h40);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'($urandom_range(1)), 3'(i), 16'($urandom), 1'($urandom), 1'b1);

    // Reset on a pop edge discards buffered entries
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd3, 16'hBBBB, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    check("t6_r2", 32'(r2), 0);
    check("t6_r3", 32'(r3), 0);
    check("t6_empty", 32'(empty), 1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(49) != 0), 1'($urandom_range(1)), 3'($urandom_range(7)),
           (($urandom_range(7) == 0) ? 16'h0 : 16'($urandom)), 1'($urandom),
           1'($urandom_range(9) < 7));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
